// File: rtl/exception_ctrl.sv
// Memory-stage exception detection, prioritisation and commit.
// Drives the CP0 exception-update port and the pipeline redirect, then drains wrong-path work.
module exception_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int          DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic [31:0] mem_addr_i,
    input  logic [7:0]  exc_flags_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        cp0_we_i,
    input  logic [4:0]  cp0_waddr_i,
    input  logic [31:0] cp0_wdata_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        draining_o
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    localparam logic [4:0] ADDR_STATUS = 5'd12;
    localparam logic [4:0] ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] ADDR_EPC    = 5'd14;

    localparam logic [3:0] CNT_LOAD = 4'(DRAIN_CYCLES - 1);

    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        int_q, int_d;

    logic [31:0] status_e, cause_e, epc_e;
    logic        int_raw;
    logic        take;

    // Forward a CP0 write committing this cycle; software may only write cause IP[1:0].
    always_comb begin
        status_e = cp0_status_i;
        cause_e  = cp0_cause_i;
        epc_e    = cp0_epc_i;
        if (cp0_we_i && cp0_waddr_i == ADDR_STATUS) status_e = cp0_wdata_i;
        if (cp0_we_i && cp0_waddr_i == ADDR_CAUSE)  cause_e[9:8] = cp0_wdata_i[9:8];
        if (cp0_we_i && cp0_waddr_i == ADDR_EPC)    epc_e = cp0_wdata_i;
    end

    assign int_raw = status_e[0] & ~status_e[1] & (|(cause_e[15:8] & status_e[15:8]));

    logic unused_cp0_bits;
    assign unused_cp0_bits = ^{status_e[31:16], status_e[7:2], cause_e[31:16], cause_e[7:0]};

    // Nothing is committed during reset or the drain window.
    assign take = (state_q == IDLE) & mem_valid_i & ~stall_i & ~rst;

    always_comb begin
        excepttype_o = 32'h0;
        bad_addr_o   = 32'h0;
        if (take) begin
            if (int_q)                excepttype_o = 32'h1;
            else if (exc_flags_i[0]) begin
                excepttype_o = 32'h4;
                bad_addr_o   = mem_pc_i;
            end
            else if (exc_flags_i[1]) excepttype_o = 32'ha;
            else if (exc_flags_i[2]) excepttype_o = 32'hc;
            else if (exc_flags_i[3]) excepttype_o = 32'h8;
            else if (exc_flags_i[4]) excepttype_o = 32'h9;
            else if (exc_flags_i[5]) excepttype_o = 32'he;
            else if (exc_flags_i[6]) begin
                excepttype_o = 32'h4;
                bad_addr_o   = mem_addr_i;
            end
            else if (exc_flags_i[7]) begin
                excepttype_o = 32'h5;
                bad_addr_o   = mem_addr_i;
            end
        end
    end

    assign flush_o             = (excepttype_o != 32'h0);
    assign new_pc_o            = (excepttype_o == 32'he) ? epc_e :
                                 flush_o                 ? EXC_VECTOR : 32'h0;
    assign current_inst_addr_o = mem_pc_i;
    assign is_in_delayslot_o   = mem_in_delayslot_i;
    assign draining_o          = (state_q == DRAIN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        int_d   = int_raw;
        if (flush_o || state_q == DRAIN) int_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_o) begin
                    state_d = DRAIN;
                    cnt_d   = CNT_LOAD;
                end
            end
            default: begin
                if (cnt_q == 4'd0) state_d = IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            int_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            int_q   <= int_d;
        end
    end

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed self-checking bench for exception_ctrl: one task per scenario, inline comparisons.
module tb_exception_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        mem_valid_i;
    logic [31:0] mem_pc_i;
    logic        mem_in_delayslot_i;
    logic [31:0] mem_addr_i;
    logic [7:0]  exc_flags_i;
    logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
    logic        cp0_we_i;
    logic [4:0]  cp0_waddr_i;
    logic [31:0] cp0_wdata_i;
    logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, new_pc_o;
    logic        is_in_delayslot_o, flush_o, draining_o;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] VEC = 32'hBFC00380;

    exception_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .stall_i             (stall_i),
        .mem_valid_i         (mem_valid_i),
        .mem_pc_i            (mem_pc_i),
        .mem_in_delayslot_i  (mem_in_delayslot_i),
        .mem_addr_i          (mem_addr_i),
        .exc_flags_i         (exc_flags_i),
        .cp0_status_i        (cp0_status_i),
        .cp0_cause_i         (cp0_cause_i),
        .cp0_epc_i           (cp0_epc_i),
        .cp0_we_i            (cp0_we_i),
        .cp0_waddr_i         (cp0_waddr_i),
        .cp0_wdata_i         (cp0_wdata_i),
        .excepttype_o        (excepttype_o),
        .current_inst_addr_o (current_inst_addr_o),
        .is_in_delayslot_o   (is_in_delayslot_o),
        .bad_addr_o          (bad_addr_o),
        .flush_o             (flush_o),
        .new_pc_o            (new_pc_o),
        .draining_o          (draining_o)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are then driven and checked mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall_i = 0; mem_valid_i = 0; mem_pc_i = 0; mem_in_delayslot_i = 0;
        mem_addr_i = 0; exc_flags_i = 0; cp0_we_i = 0; cp0_waddr_i = 0; cp0_wdata_i = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        cp0_status_i = 0; cp0_cause_i = 0; cp0_epc_i = 0;
        mem_valid_i = 1; exc_flags_i = 8'h04; mem_pc_i = 32'h1234; mem_in_delayslot_i = 1;
        tick(); tick(); #1;
        total++; if (excepttype_o !== 32'h0) begin bad++; $display("FAIL reset_exc: got %h expected %h", excepttype_o, 32'h0); end
        total++; if (flush_o !== 1'b0) begin bad++; $display("FAIL reset_flush: got %b expected 0", flush_o); end
        total++; if (draining_o !== 1'b0) begin bad++; $display("FAIL reset_drain: got %b expected 0", draining_o); end
        total++; if (new_pc_o !== 32'h0) begin bad++; $display("FAIL reset_newpc: got %h expected 0", new_pc_o); end
        total++; if (current_inst_addr_o !== 32'h1234) begin bad++; $display("FAIL reset_pc: got %h expected 00001234", current_inst_addr_o); end
        total++; if (is_in_delayslot_o !== 1'b1) begin bad++; $display("FAIL reset_ds: got %b expected 1", is_in_delayslot_o); end
        tick(); rst = 0; idle_inputs();
        $display("test_reset: outputs idle under reset");
    endtask

    task automatic test_syscall();
        tick();
        mem_valid_i = 1; exc_flags_i = 8'h08; mem_pc_i = 32'hBFC00100; #1;
        total++; if (excepttype_o !== 32'h8) begin bad++; $display("FAIL sys_exc: got %h expected 00000008", excepttype_o); end
        total++; if (flush_o !== 1'b1) begin bad++; $display("FAIL sys_flush: got %b expected 1", flush_o); end
        total++; if (new_pc_o !== VEC) begin bad++; $display("FAIL sys_newpc: got %h expected %h", new_pc_o, VEC); end
        total++; if (bad_addr_o !== 32'h0) begin bad++; $display("FAIL sys_badaddr: got %h expected 0", bad_addr_o); end
        for (int i = 0; i < 2; i++) begin
            tick(); #1;
            total++; if (draining_o !== 1'b1) begin bad++; $display("FAIL sys_drain%0d: got %b expected 1", i, draining_o); end
            total++; if (excepttype_o !== 32'h0 || flush_o !== 1'b0) begin bad++; $display("FAIL sys_ignored%0d: got exc=%h flush=%b expected 0/0", i, excepttype_o, flush_o); end
        end
        tick(); #1;
        total++; if (draining_o !== 1'b0 || excepttype_o !== 32'h8) begin bad++; $display("FAIL sys_retake: got drain=%b exc=%h expected 0/8", draining_o, excepttype_o); end
        idle_inputs(); tick(); tick();
        $display("test_syscall: syscall at bfc00100 redirected to %h", VEC);
    endtask

    task automatic test_eret();
        tick();
        mem_valid_i = 1; exc_flags_i = 8'h20; mem_pc_i = 32'h80000040; cp0_epc_i = 32'h100;
        cp0_we_i = 1; cp0_waddr_i = 5'd14; cp0_wdata_i = 32'hBFC00200; #1;
        total++; if (excepttype_o !== 32'he) begin bad++; $display("FAIL eret_exc: got %h expected 0000000e", excepttype_o); end
        total++; if (new_pc_o !== 32'hBFC00200) begin bad++; $display("FAIL eret_fwd_pc: got %h expected bfc00200", new_pc_o); end
        idle_inputs(); tick(); tick(); tick();
        mem_valid_i = 1; exc_flags_i = 8'h20; #1;
        total++; if (new_pc_o !== 32'h100) begin bad++; $display("FAIL eret_plain_pc: got %h expected 00000100", new_pc_o); end
        idle_inputs(); tick(); tick();
        $display("test_eret: forwarded and plain epc");
    endtask

    task automatic test_interrupt();
        tick();
        cp0_status_i = 32'h0000FF01; cp0_cause_i = 0; mem_valid_i = 1; mem_pc_i = 32'h80001000; #1;
        total++; if (excepttype_o !== 32'h0) begin bad++; $display("FAIL int_before: got %h expected 0", excepttype_o); end
        tick();
        cp0_cause_i = 32'h400; #1;
        total++; if (excepttype_o !== 32'h0) begin bad++; $display("FAIL int_cycle_n: got %h expected 0", excepttype_o); end
        tick();
        exc_flags_i = 8'h08; mem_pc_i = 32'h80001004; cp0_cause_i = 0; #1;
        total++; if (excepttype_o !== 32'h1) begin bad++; $display("FAIL int_taken: got %h expected 00000001", excepttype_o); end
        total++; if (new_pc_o !== VEC) begin bad++; $display("FAIL int_newpc: got %h expected %h", new_pc_o, VEC); end
        exc_flags_i = 0; tick(); tick(); tick(); #1;
        total++; if (excepttype_o !== 32'h0) begin bad++; $display("FAIL int_cleared: got %h expected 0", excepttype_o); end
        // EXL set: never pending
        cp0_status_i = 32'h0000FF03; cp0_cause_i = 32'h400;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            total++; if (excepttype_o !== 32'h0) begin bad++; $display("FAIL int_exl%0d: got %h expected 0", i, excepttype_o); end
        end
        // Same-cycle status write clearing IE masks the interrupt
        cp0_status_i = 32'h0000FF01; cp0_we_i = 1; cp0_waddr_i = 5'd12; cp0_wdata_i = 32'h0000FF00;
        tick(); cp0_we_i = 0; #1;
        total++; if (excepttype_o !== 32'h0) begin bad++; $display("FAIL int_ie_fwd: got %h expected 0", excepttype_o); end
        cp0_cause_i = 0; idle_inputs(); tick(); tick(); tick(); tick();
        cp0_status_i = 0;
        $display("test_interrupt: one-cycle latency, EXL and IE masking");
    endtask

    task automatic test_priority();
        tick();
        mem_valid_i = 1; exc_flags_i = 8'h81; mem_pc_i = 32'h80000003; mem_addr_i = 32'h1; #1;
        total++; if (excepttype_o !== 32'h4 || bad_addr_o !== 32'h80000003) begin bad++; $display("FAIL prio_fetch: got exc=%h bad=%h expected 4/80000003", excepttype_o, bad_addr_o); end
        idle_inputs(); tick(); tick(); tick();
        mem_valid_i = 1; exc_flags_i = 8'h80; mem_pc_i = 32'h80000000; mem_addr_i = 32'h1; #1;
        total++; if (excepttype_o !== 32'h5 || bad_addr_o !== 32'h1) begin bad++; $display("FAIL prio_store: got exc=%h bad=%h expected 5/1", excepttype_o, bad_addr_o); end
        idle_inputs(); tick(); tick(); tick();
        mem_valid_i = 1; exc_flags_i = 8'h06; mem_addr_i = 32'h55; #1;
        total++; if (excepttype_o !== 32'ha || bad_addr_o !== 32'h0) begin bad++; $display("FAIL prio_ri: got exc=%h bad=%h expected a/0", excepttype_o, bad_addr_o); end
        idle_inputs(); tick(); tick(); tick();
        mem_valid_i = 1; exc_flags_i = 8'hC0; mem_addr_i = 32'h0000_0102; #1;
        total++; if (excepttype_o !== 32'h4 || bad_addr_o !== 32'h102) begin bad++; $display("FAIL prio_load: got exc=%h bad=%h expected 4/102", excepttype_o, bad_addr_o); end
        idle_inputs(); tick(); tick();
        $display("test_priority: fetch/store/ri/load ordering");
    endtask

    task automatic test_stall_reset();
        tick();
        mem_valid_i = 1; exc_flags_i = 8'h04; mem_pc_i = 32'h200; stall_i = 1; #1;
        total++; if (excepttype_o !== 32'h0 || flush_o !== 1'b0) begin bad++; $display("FAIL stall_hold: got exc=%h flush=%b expected 0/0", excepttype_o, flush_o); end
        tick(); stall_i = 0; #1;
        total++; if (excepttype_o !== 32'hc || flush_o !== 1'b1) begin bad++; $display("FAIL stall_release: got exc=%h flush=%b expected c/1", excepttype_o, flush_o); end
        tick(); rst = 1; #1;
        total++; if (draining_o !== 1'b1 || flush_o !== 1'b0) begin bad++; $display("FAIL rst_in_drain: got drain=%b flush=%b expected 1/0", draining_o, flush_o); end
        tick(); rst = 0; mem_valid_i = 0; #1;
        total++; if (draining_o !== 1'b0) begin bad++; $display("FAIL rst_to_idle: got %b expected 0", draining_o); end
        tick(); tick();
        mem_valid_i = 1; exc_flags_i = 8'h04; #1;
        total++; if (excepttype_o !== 32'hc) begin bad++; $display("FAIL after_rst_ov: got %h expected 0000000c", excepttype_o); end
        idle_inputs(); tick(); tick();
        $display("test_stall_reset: stall hold, reset in drain");
    endtask

    initial begin
        test_reset();
        test_syscall();
        test_eret();
        test_interrupt();
        test_priority();
        test_stall_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
